// File: rtl/instr_register_pkg.sv
// Shared types for instr_register and its execute stage: opcodes, operand and
// address widths, the instruction word, the 64-bit result and the execute FSM
// state encoding. Also holds the single-cycle ALU used by instr_exec_unit.
package instr_register_pkg;

  localparam int OPERAND_W = 32;
  localparam int RESULT_W  = 64;
  localparam int ADDR_W    = 5;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic        [ADDR_W-1:0]    address_t;
  typedef logic signed [RESULT_W-1:0]  result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    DIVW  = 3'd3,
    WRITE = 3'd4
  } exec_state_t;

  function automatic logic is_divide(input opcode_t opc);
    return (opc == DIV) || (opc == MOD);
  endfunction

  // Single-cycle opcodes; operands are sign-extended to 64 bits first so
  // ADD/SUB cannot overflow and MULT yields the full product.
  // DIV/MOD are handled by the caller and return 0 here.
  function automatic result_t alu_simple(input instruction_t ir);
    result_t a;
    result_t b;
    result_t r;
    a = result_t'(ir.op_a);
    b = result_t'(ir.op_b);
    case (ir.opc)
      ZERO:    r = '0;
      PASSA:   r = a;
      PASSB:   r = b;
      ADD:     r = a + b;
      SUB:     r = a - b;
      MULT:    r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_exec_div.sv
// Signed restoring divider, one quotient bit per cycle on operand magnitudes.
// Latency: div_done asserts DIV_ITER cycles after the div_start edge, for one cycle.
// Backpressure: none; div_start restarts the divider unconditionally, reset aborts it.
// Ports: clk, reset_n (async active-low), div_start, dividend, divisor (signed),
//        div_done, quotient (DIV_ITER+1 bits signed), remainder (DIV_ITER bits signed).
// Compiled into the design only when EXEC_DIV_EN is defined.
module instr_exec_div #(
  parameter int DIV_ITER = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       div_start,
  input  logic signed [DIV_ITER-1:0] dividend,
  input  logic signed [DIV_ITER-1:0] divisor,
  output logic                       div_done,
  output logic signed [DIV_ITER:0]   quotient,
  output logic signed [DIV_ITER-1:0] remainder
);

  localparam int CW = $clog2(DIV_ITER + 1);
  localparam logic [CW-1:0] ITER_CNT = CW'(DIV_ITER);

  logic [DIV_ITER-1:0] quo_q;
  logic [DIV_ITER-1:0] den_q;
  logic [DIV_ITER-1:0] rem_q;
  logic [CW-1:0]       cnt_q;
  logic                run_q;
  logic                neg_quo_q;
  logic                neg_rem_q;

  logic [DIV_ITER:0]   rem_sh;
  logic                ge;
  logic [DIV_ITER-1:0] rem_next;

  function automatic logic [DIV_ITER-1:0] mag(input logic signed [DIV_ITER-1:0] v);
    // The most negative value maps onto its own bit pattern, which read as
    // unsigned is the correct magnitude.
    return v[DIV_ITER-1] ? DIV_ITER'(-v) : DIV_ITER'(v);
  endfunction

  // Partial remainder is always below the divisor, so the shifted value fits
  // DIV_ITER+1 bits and the difference fits DIV_ITER bits.
  always_comb begin
    rem_sh   = {rem_q, quo_q[DIV_ITER-1]};
    ge       = (rem_sh >= {1'b0, den_q});
    rem_next = ge ? (rem_sh[DIV_ITER-1:0] - den_q) : rem_sh[DIV_ITER-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (div_start) begin
      quo_q     <= mag(dividend);
      den_q     <= mag(divisor);
      rem_q     <= '0;
      cnt_q     <= ITER_CNT;
      run_q     <= 1'b1;
      neg_quo_q <= dividend[DIV_ITER-1] ^ divisor[DIV_ITER-1];
      neg_rem_q <= dividend[DIV_ITER-1];
    end else if (run_q) begin
      if (cnt_q != '0) begin
        rem_q <= rem_next;
        quo_q <= {quo_q[DIV_ITER-2:0], ge};
        cnt_q <= cnt_q - CW'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign div_done = run_q && (cnt_q == '0);

  // Truncation toward zero; remainder takes the dividend's sign.
  assign quotient  = neg_quo_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});
  assign remainder = neg_rem_q ? -$signed(rem_q) : $signed(rem_q);

endmodule

// File: rtl/instr_exec_unit.sv
// Execute stage behind instr_register: fetches a wrapping range of entries and emits one result each.
// Latency: 3 cycles per instruction (FETCH, EXEC, WRITE); DIV/MOD with the divider take 36.
// Backpressure: none; result_valid is a pulse, start is ignored unless the unit is idle.
// Ports: clk, reset_n (async active-low), start, first_ptr, last_ptr -> read_pointer;
//        instruction_word (combinational from instr_register); busy, result_valid,
//        result_ptr, result, err_div0, done (all registered).
// Macro EXEC_DIV_EN: when defined, instantiates instr_exec_div for DIV/MOD;
// when undefined, DIV/MOD finish in EXEC with result 0 and err_div0 = 1.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     first_ptr,
  input  address_t     last_ptr,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         busy,
  output logic         result_valid,
  output address_t     result_ptr,
  output result_t      result,
  output logic         err_div0,
  output logic         done
);

  exec_state_t  state;
  address_t     ptr;
  address_t     last;
  instruction_t ir;

  result_t exec_res;
  logic    exec_err;
  logic    exec_long;

  always_comb begin
    exec_res  = alu_simple(ir);
    exec_err  = 1'b0;
    exec_long = 1'b0;
    if (is_divide(ir.opc)) begin
      exec_res = '0;
`ifdef EXEC_DIV_EN
      exec_err  = (ir.op_b == '0);
      exec_long = (ir.op_b != '0);
`else
      exec_err  = 1'b1;
`endif
    end
  end

`ifdef EXEC_DIV_EN
  logic                       div_start;
  logic                       div_done;
  logic signed [DIV_ITER:0]   div_quo;
  logic signed [DIV_ITER-1:0] div_rem;

  assign div_start = (state == EXEC) && exec_long;

  instr_exec_div #(
    .DIV_ITER (DIV_ITER)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .div_start (div_start),
    .dividend  (ir.op_a),
    .divisor   (ir.op_b),
    .div_done  (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  // The pointer register drives the read port directly; it only changes on
  // run start and in WRITE, so it is stable throughout FETCH.
  assign read_pointer = ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      last         <= '0;
      ir           <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_ptr   <= '0;
      result       <= '0;
      err_div0     <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          done         <= 1'b0;
          if (start) begin
            ptr   <= first_ptr;
            last  <= last_ptr;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end

        FETCH: begin
          ir    <= instruction_word;
          state <= EXEC;
        end

        EXEC: begin
          if (exec_long) begin
            state <= DIVW;
          end else begin
            // Outputs are loaded on entry to WRITE so they are visible
            // for exactly the WRITE cycle.
            result       <= exec_res;
            err_div0     <= exec_err;
            result_ptr   <= ptr;
            result_valid <= 1'b1;
            done         <= (ptr == last);
            state        <= WRITE;
          end
        end

        DIVW: begin
`ifdef EXEC_DIV_EN
          if (div_done) begin
            result       <= (ir.opc == DIV) ? result_t'(div_quo) : result_t'(div_rem);
            err_div0     <= 1'b0;
            result_ptr   <= ptr;
            result_valid <= 1'b1;
            done         <= (ptr == last);
            state        <= WRITE;
          end
`else
          // Unreachable without the divider; recover to IDLE if ever entered.
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end

        WRITE: begin
          result_valid <= 1'b0;
          done         <= 1'b0;
          if (ptr == last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ptr   <= ptr + address_t'(1);
            state <= FETCH;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed runs against a timing/result model that
// predicts, per start, which cycle each result appears on and what it holds.
// Works for both builds (with and without EXEC_DIV_EN).
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  address_t     first_ptr = '0;
  address_t     last_ptr = '0;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         busy;
  logic         result_valid;
  address_t     result_ptr;
  result_t      result;
  logic         err_div0;
  logic         done;

  instruction_t mem [32];
  assign instruction_word = mem[read_pointer];

  instr_exec_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .first_ptr        (first_ptr),
    .last_ptr         (last_ptr),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .busy             (busy),
    .result_valid     (result_valid),
    .result_ptr       (result_ptr),
    .result           (result),
    .err_div0         (err_div0),
    .done             (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int       t;
    address_t p;
    longint   r;
    bit       e;
    bit       d;
  } exp_t;

  exp_t     q[$];
  int       busy_lo = 0;
  int       busy_hi = -1;
  longint   held_r = 0;
  address_t held_p = '0;
  bit       held_e = 1'b0;
  bit       chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t w;
    w.opc  = o;
    w.op_a = a;
    w.op_b = b;
    return w;
  endfunction

  // What an instruction must produce, straight from the opcode rules.
  function automatic void model_exec(input opcode_t o, input int a, input int b,
                                     output longint r, output bit e, output bit lng);
    r = 0; e = 1'b0; lng = 1'b0;
    case (o)
      ZERO:  r = 0;
      PASSA: r = a;
      PASSB: r = b;
      ADD:   r = longint'(a) + longint'(b);
      SUB:   r = longint'(a) - longint'(b);
      MULT:  r = longint'(a) * longint'(b);
      default: begin
`ifdef EXEC_DIV_EN
        if (b == 0) e = 1'b1;
        else begin
          lng = 1'b1;
          r = (o == DIV) ? longint'(a) / longint'(b) : longint'(a) % longint'(b);
        end
`else
        e = 1'b1;
`endif
      end
    endcase
  endfunction

  // Cycle-by-cycle comparison against the model (after each edge, at negedge).
  always @(negedge clk) begin
    bit   ev;
    exp_t x;
    if (chk_en && reset_n) begin
      while (q.size() > 0 && q[0].t < cyc) void'(q.pop_front());
      ev = (q.size() > 0) && (q[0].t == cyc);
      chk("result_valid", result_valid, ev);
      chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      if (ev) begin
        x = q.pop_front();
        chk("result_ptr", result_ptr, x.p);
        chk("result", result, x.r);
        chk("err_div0", err_div0, x.e);
        chk("done", done, x.d);
        held_r = x.r; held_p = x.p; held_e = x.e;
      end else begin
        chk("done_idle", done, 0);
        chk("result_hold", result, held_r);
        chk("result_ptr_hold", result_ptr, held_p);
        chk("err_div0_hold", err_div0, held_e);
      end
    end
  end

  // Issue a start on the first idle cycle and predict the whole run.
  task automatic run(input address_t f, input address_t l, output int n);
    address_t p;
    int       fe, wr, g;
    longint   r;
    bit       e, lng;
    exp_t     x;
    g = 0;
    @(negedge clk);
    while (busy && g < 4000) begin @(negedge clk); g++; end
    chk("run_wait_idle", busy, 0);
    start = 1'b1; first_ptr = f; last_ptr = l;
    n = cyc + 1;
    p = f; fe = n; wr = n;
    for (int i = 0; i < 32; i++) begin
      model_exec(mem[p].opc, mem[p].op_a, mem[p].op_b, r, e, lng);
      wr = fe + (lng ? 35 : 2);
      x.t = wr; x.p = p; x.r = r; x.e = e; x.d = (p == l);
      q.push_back(x);
      if (p == l) break;
      p = p + address_t'(1);
      fe = wr + 1;
    end
    busy_lo = n; busy_hi = wr;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while ((q.size() > 0 || cyc <= busy_hi) && g < 4000) begin @(negedge clk); g++; end
    chk({tag, "_timeout"}, q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    reset_n = 1'b0;
    q.delete(); busy_hi = -1; held_r = 0; held_p = '0; held_e = 1'b0;
    #1;
    chk({tag, "_read_pointer"}, read_pointer, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_result_ptr"}, result_ptr, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_err_div0"}, err_div0, 0);
    chk({tag, "_done"}, done, 0);
    repeat (2) @(posedge clk); #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  initial begin
    int     n;
    longint r;
    bit     e, lng;
    for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0);

    // Pin the model with hand-computed values.
    model_exec(ADD, 5, -3, r, e, lng);          chk("pin_add", r, 2);
    model_exec(SUB, 1, 4, r, e, lng);           chk("pin_sub", r, -3);
    model_exec(MULT, -3, 100000, r, e, lng);    chk("pin_mult", r, -300000);
    model_exec(DIV, 9, 0, r, e, lng);           chk("pin_div0_err", e, 1);
`ifdef EXEC_DIV_EN
    model_exec(DIV, -7, 2, r, e, lng);          chk("pin_div", r, -3);
    model_exec(MOD, -7, 2, r, e, lng);          chk("pin_mod", r, -1);
`else
    model_exec(DIV, 9, 3, r, e, lng);           chk("pin_nodiv", r, 0);
`endif

    // Power-on reset.
    #1 reset_n = 1'b0;
    #2;
    chk("por_read_pointer", read_pointer, 0);
    chk("por_busy", busy, 0);
    chk("por_result_valid", result_valid, 0);
    chk("por_result", result, 0);
    chk("por_done", done, 0);
    repeat (2) @(posedge clk); #2;
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Single ADD, first == last.
    mem[0] = mk(ADD, 5, -3);
    run(5'd0, 5'd0, n);
    while (cyc < n + 1) @(negedge clk);
    chk("add_busy_fetch_exec", busy, 1);
    chk("add_valid_early", result_valid, 0);
    while (cyc < n + 2) @(negedge clk);
    chk("add_valid", result_valid, 1);
    chk("add_result", result, 2);
    chk("add_ptr", result_ptr, 0);
    chk("add_done", done, 1);
    wait_idle("add");
    chk("add_busy_after", busy, 0);

    // Wrapping run 30 -> 1.
    mem[30] = mk(PASSA, 7, 99);
    mem[31] = mk(SUB, 1, 4);
    mem[0]  = mk(MULT, -3, 100000);
    mem[1]  = mk(ZERO, 11, 12);
    run(5'd30, 5'd1, n);
    wait_idle("wrap");
    chk("wrap_held_result", result, 0);
    chk("wrap_held_ptr", result_ptr, 1);

    // Divide then modulo.
    mem[2] = mk(DIV, -7, 2);
    mem[3] = mk(MOD, -7, 2);
    run(5'd2, 5'd3, n);
    wait_idle("divmod");
`ifdef EXEC_DIV_EN
    chk("divmod_held_result", result, -1);
`else
    chk("divmod_held_err", err_div0, 1);
`endif

    // Divide by zero, then a legal divide.
    mem[4] = mk(DIV, 9, 0);
    mem[5] = mk(DIV, 9, 3);
    run(5'd4, 5'd5, n);
    while (cyc < n + 2) @(negedge clk);
    chk("div0_valid", result_valid, 1);
    chk("div0_err", err_div0, 1);
    chk("div0_result", result, 0);
    wait_idle("div0");

    // All 32 entries: first == last + 1.
    for (int i = 0; i < 32; i++) mem[i] = mk(opcode_t'(i % 8), i * 1000 - 7000, (i % 5) - 2);
    run(5'd5, 5'd4, n);
    wait_idle("full");

    // Start pulses during a run are ignored.
    run(5'd10, 5'd13, n);
    repeat (2) @(negedge clk);
    start = 1'b1; first_ptr = 5'd20; last_ptr = 5'd20;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    run(5'd13, 5'd13, n);
    wait_idle("after_busy");

    // Reset mid-run; no result may follow.
    run(5'd0, 5'd31, n);
    repeat (6) @(negedge clk);
    do_reset("midrun");
    repeat (40) @(negedge clk);

    // Reset while a divide is in progress, then a clean divide run.
    mem[2] = mk(DIV, -7, 2);
    mem[3] = mk(MOD, -7, 2);
    run(5'd2, 5'd2, n);
    repeat (12) @(negedge clk);
    do_reset("middiv");
    repeat (40) @(negedge clk);
    run(5'd2, 5'd3, n);
    wait_idle("div_again");

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
